video_layer_mixer: RTL and testbench

VIDEO_LAYER_MIXER -- requirements
Module: video_layer_mixer

---
 rtl/video_pkg.sv | 14 +
 rtl/video_prio_select.sv | 31 +++
 rtl/video_layer_mixer.sv | 185 ++++++++++++++++++
 tb/tb_video_layer_mixer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants and pixel type for the video layer mixer.
package video_pkg;

    localparam int COLSPC_DEF  = 10;
    localparam int ALPHA_W     = 8;
    localparam int MIX_LATENCY = 3;

    typedef struct packed {
        logic [COLSPC_DEF-1:0] r;
        logic [COLSPC_DEF-1:0] g;
        logic [COLSPC_DEF-1:0] b;
    } rgb_t;

endpackage

// File: rtl/video_prio_select.sv
// Finds the lowest- and second-lowest-index opaque layers; index NLAYERS means none.
module video_prio_select
    import video_pkg::*;
#(
    parameter int NLAYERS = 8,
    parameter int SEL_W   = $clog2(NLAYERS + 1)
) (
    input  logic [NLAYERS-1:0] opaque,
    output logic [SEL_W-1:0]   first_idx,
    output logic               first_found,
    output logic [SEL_W-1:0]   second_idx,
    output logic               second_found
);

    // Scanning downward lets each hit demote the previous best to second place.
    always_comb begin
        first_idx    = SEL_W'(NLAYERS);
        first_found  = 1'b0;
        second_idx   = SEL_W'(NLAYERS);
        second_found = 1'b0;
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                second_idx   = first_idx;
                second_found = first_found;
                first_idx    = SEL_W'(i);
                first_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_layer_mixer.sv
// Priority layer mixer with a fixed 3-stage pipeline and frame-synchronous shadow config.
// Optional layer-0 alpha blend is enabled by defining VIDEO_MIXER_ALPHA_EN.
module video_layer_mixer
    import video_pkg::*;
#(
    parameter int NLAYERS = 8,
    parameter int COLSPC  = COLSPC_DEF,
    parameter int FCNT_W  = 16
) (
    input  logic                             video_clk_pix,
    input  logic                             video_rst,
    input  logic                             video_enable,
    input  logic                             hsync,
    input  logic                             vsync,
    input  logic                             frame_start,
    input  logic                             line_start,
    input  logic [NLAYERS-1:0][COLSPC-1:0]   layer_red,
    input  logic [NLAYERS-1:0][COLSPC-1:0]   layer_green,
    input  logic [NLAYERS-1:0][COLSPC-1:0]   layer_blue,
    input  logic [NLAYERS-1:0]               cfg_layer_en,
    input  logic [COLSPC-1:0]                cfg_bg_red,
    input  logic [COLSPC-1:0]                cfg_bg_green,
    input  logic [COLSPC-1:0]                cfg_bg_blue,
    input  logic [ALPHA_W-1:0]               cfg_alpha,
    output logic [COLSPC-1:0]                red,
    output logic [COLSPC-1:0]                green,
    output logic [COLSPC-1:0]                blue,
    output logic                             o_video_enable,
    output logic                             o_hsync,
    output logic                             o_vsync,
    output logic                             o_frame_start,
    output logic                             o_line_start,
    output logic [$clog2(NLAYERS+1)-1:0]     layer_sel,
    output logic [FCNT_W-1:0]                frame_count
);

    localparam int SEL_W = $clog2(NLAYERS + 1);

    typedef struct packed {
        logic [COLSPC-1:0] r;
        logic [COLSPC-1:0] g;
        logic [COLSPC-1:0] b;
    } pix_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
    } tim_t;

    logic [NLAYERS-1:0]            mask_q, mask_d, mask_eff;
    pix_t                          bg_q, bg_d, bg_eff;
    logic [ALPHA_W-1:0]            alpha_q, alpha_d, alpha_eff;
    logic [FCNT_W-1:0]             frame_count_q, frame_count_d;
    pix_t [NLAYERS-1:0]            pix_s1_q, pix_s1_d;
    logic [NLAYERS-1:0]            opq_s1_q, opq_s1_d;
    pix_t                          bg_s1_q, bg_s1_d;
    logic [ALPHA_W-1:0]            alpha_s1_q, alpha_s1_d;
    pix_t                          top_s2_q, top_s2_d;
    pix_t                          below_s2_q, below_s2_d;
    logic [SEL_W-1:0]              sel_s2_q, sel_s2_d;
    logic                          l0_s2_q, l0_s2_d;
    logic [ALPHA_W-1:0]            alpha_s2_q, alpha_s2_d;
    pix_t                          out_q, out_d;
    logic [SEL_W-1:0]              sel_q, sel_d;
    tim_t [MIX_LATENCY-1:0]        tim_q, tim_d;
    logic [SEL_W-1:0]              first_idx, second_idx;
    logic                          first_found, second_found;

    video_prio_select #(.NLAYERS(NLAYERS), .SEL_W(SEL_W)) u_prio (
        .opaque       (opq_s1_q),
        .first_idx    (first_idx),
        .first_found  (first_found),
        .second_idx   (second_idx),
        .second_found (second_found)
    );

`ifdef VIDEO_MIXER_ALPHA_EN
    // Widest sum is top*256 + below*255, which fits in COLSPC+9 bits.
    function automatic logic [COLSPC-1:0] blend(input logic [COLSPC-1:0] t,
                                                input logic [COLSPC-1:0] b,
                                                input logic [ALPHA_W-1:0] a);
        logic [COLSPC+8:0] acc;
        acc = (COLSPC+9)'(t) * (COLSPC+9)'({1'b0, a} + 9'd1)
            + (COLSPC+9)'(b) * (COLSPC+9)'(9'd255 - {1'b0, a});
        return acc[COLSPC+8:8];
    endfunction
`else
    logic unused_blend;
    assign unused_blend = ^{l0_s2_q, alpha_s2_q, below_s2_q};
`endif

    always_comb begin
        // A frame_start cycle sees the incoming config immediately.
        mask_eff      = frame_start ? cfg_layer_en : mask_q;
        bg_eff        = frame_start ? pix_t'{cfg_bg_red, cfg_bg_green, cfg_bg_blue} : bg_q;
        alpha_eff     = frame_start ? cfg_alpha : alpha_q;
        mask_d        = mask_eff;
        bg_d          = bg_eff;
        alpha_d       = alpha_eff;
        frame_count_d = frame_start ? frame_count_q + FCNT_W'(1) : frame_count_q;

        for (int i = 0; i < NLAYERS; i++) begin
            pix_s1_d[i] = pix_t'{layer_red[i], layer_green[i], layer_blue[i]};
            opq_s1_d[i] = mask_eff[i] & (|{layer_red[i], layer_green[i], layer_blue[i]});
        end
        bg_s1_d    = bg_eff;
        alpha_s1_d = alpha_eff;
        tim_d      = {tim_q[MIX_LATENCY-2:0],
                      tim_t'{video_enable, hsync, vsync, frame_start, line_start}};

        top_s2_d   = bg_s1_q;
        below_s2_d = bg_s1_q;
        for (int i = 0; i < NLAYERS; i++) begin
            if (first_found && first_idx == SEL_W'(i)) top_s2_d = pix_s1_q[i];
            if (second_found && second_idx == SEL_W'(i)) below_s2_d = pix_s1_q[i];
        end
        sel_s2_d   = first_idx;
        l0_s2_d    = first_found && (first_idx == '0);
        alpha_s2_d = alpha_s1_q;

        out_d = top_s2_q;
`ifdef VIDEO_MIXER_ALPHA_EN
        if (l0_s2_q) begin
            out_d.r = blend(top_s2_q.r, below_s2_q.r, alpha_s2_q);
            out_d.g = blend(top_s2_q.g, below_s2_q.g, alpha_s2_q);
            out_d.b = blend(top_s2_q.b, below_s2_q.b, alpha_s2_q);
        end
`endif
        if (!tim_q[1].de) out_d = '0;
        sel_d = sel_s2_q;
    end

    always_ff @(posedge video_clk_pix) begin
        if (video_rst) begin
            mask_q        <= '1;
            bg_q          <= '0;
            alpha_q       <= '1;
            frame_count_q <= '0;
            pix_s1_q      <= '0;
            opq_s1_q      <= '0;
            bg_s1_q       <= '0;
            alpha_s1_q    <= '1;
            top_s2_q      <= '0;
            below_s2_q    <= '0;
            sel_s2_q      <= SEL_W'(NLAYERS);
            l0_s2_q       <= 1'b0;
            alpha_s2_q    <= '1;
            out_q         <= '0;
            sel_q         <= SEL_W'(NLAYERS);
            tim_q         <= '0;
        end else begin
            mask_q        <= mask_d;
            bg_q          <= bg_d;
            alpha_q       <= alpha_d;
            frame_count_q <= frame_count_d;
            pix_s1_q      <= pix_s1_d;
            opq_s1_q      <= opq_s1_d;
            bg_s1_q       <= bg_s1_d;
            alpha_s1_q    <= alpha_s1_d;
            top_s2_q      <= top_s2_d;
            below_s2_q    <= below_s2_d;
            sel_s2_q      <= sel_s2_d;
            l0_s2_q       <= l0_s2_d;
            alpha_s2_q    <= alpha_s2_d;
            out_q         <= out_d;
            sel_q         <= sel_d;
            tim_q         <= tim_d;
        end
    end

    assign red            = out_q.r;
    assign green          = out_q.g;
    assign blue           = out_q.b;
    assign layer_sel      = sel_q;
    assign frame_count    = frame_count_q;
    assign o_video_enable = tim_q[MIX_LATENCY-1].de;
    assign o_hsync        = tim_q[MIX_LATENCY-1].hs;
    assign o_vsync        = tim_q[MIX_LATENCY-1].vs;
    assign o_frame_start  = tim_q[MIX_LATENCY-1].fs;
    assign o_line_start   = tim_q[MIX_LATENCY-1].ls;

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed vector bench for video_layer_mixer (default parameters).
module tb_video_layer_mixer;
    import video_pkg::*;

    localparam int NL = 8;
    localparam int CS = 10;
    localparam int FW = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     video_enable, hsync, vsync, frame_start, line_start;
    logic [NL-1:0][CS-1:0]    lr, lg, lb;
    logic [NL-1:0]            cfg_layer_en;
    logic [CS-1:0]            cfg_bg_red, cfg_bg_green, cfg_bg_blue;
    logic [7:0]               cfg_alpha;
    logic [CS-1:0]            red, green, blue;
    logic                     o_video_enable, o_hsync, o_vsync, o_frame_start, o_line_start;
    logic [3:0]               layer_sel;
    logic [FW-1:0]            frame_count;

    always #5 clk = ~clk;

    video_layer_mixer dut (
        .video_clk_pix  (clk),
        .video_rst      (rst),
        .video_enable   (video_enable),
        .hsync          (hsync),
        .vsync          (vsync),
        .frame_start    (frame_start),
        .line_start     (line_start),
        .layer_red      (lr),
        .layer_green    (lg),
        .layer_blue     (lb),
        .cfg_layer_en   (cfg_layer_en),
        .cfg_bg_red     (cfg_bg_red),
        .cfg_bg_green   (cfg_bg_green),
        .cfg_bg_blue    (cfg_bg_blue),
        .cfg_alpha      (cfg_alpha),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .o_video_enable (o_video_enable),
        .o_hsync        (o_hsync),
        .o_vsync        (o_vsync),
        .o_frame_start  (o_frame_start),
        .o_line_start   (o_line_start),
        .layer_sel      (layer_sel),
        .frame_count    (frame_count)
    );

    typedef struct {
        int         la;
        rgb_t       ca;
        int         lb2;
        rgb_t       cb;
        logic [7:0] mask;
        rgb_t       bg;
        logic [7:0] alpha;
        logic       fs;
        logic       de;
        rgb_t       ep;
        logic [3:0] es;
    } vec_t;

    vec_t            tbl[14];
    int              n_vec = 0;
    int              n_bad = 0;
    int              fc_model = 0;
    logic [4:0]      exp_q[$];

    function automatic rgb_t rgb(input int r, input int g, input int b);
        rgb_t p;
        p.r = CS'(r);
        p.g = CS'(g);
        p.b = CS'(b);
        return p;
    endfunction

    function automatic vec_t mk(input int la, input rgb_t ca, input int lb2, input rgb_t cb,
                                input logic [7:0] mask, input rgb_t bg, input logic [7:0] alpha,
                                input logic fs, input logic de, input rgb_t ep, input logic [3:0] es);
        vec_t v;
        v.la = la; v.ca = ca; v.lb2 = lb2; v.cb = cb; v.mask = mask; v.bg = bg;
        v.alpha = alpha; v.fs = fs; v.de = de; v.ep = ep; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        lr = '0; lg = '0; lb = '0;
        frame_start = 1'b0; video_enable = 1'b1;
        hsync = 1'b0; vsync = 1'b0; line_start = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        lr = '0; lg = '0; lb = '0;
        if (v.la >= 0) begin lr[v.la] = v.ca.r; lg[v.la] = v.ca.g; lb[v.la] = v.ca.b; end
        if (v.lb2 >= 0) begin lr[v.lb2] = v.cb.r; lg[v.lb2] = v.cb.g; lb[v.lb2] = v.cb.b; end
        cfg_layer_en = v.mask;
        cfg_bg_red = v.bg.r; cfg_bg_green = v.bg.g; cfg_bg_blue = v.bg.b;
        cfg_alpha = v.alpha;
        frame_start = v.fs; video_enable = v.de;
        hsync = 1'b0; vsync = 1'b0; line_start = 1'b0;
        if (v.fs) fc_model++;
    endtask

    task automatic check_pix(input string tag, input rgb_t ep, input logic [3:0] es);
        check({tag, "_red"},   32'(red),       32'(ep.r));
        check({tag, "_green"}, 32'(green),     32'(ep.g));
        check({tag, "_blue"},  32'(blue),      32'(ep.b));
        check({tag, "_sel"},   32'(layer_sel), 32'(es));
    endtask

    // One pixel in, idle afterwards, output sampled exactly three edges later.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk); drive_vec(v);
        @(negedge clk); drive_idle();
        @(posedge clk); @(posedge clk); #1;
        check_pix(tag, v.ep, v.es);
    endtask

    initial begin
        rgb_t z, a, b2;
        z = rgb(0, 0, 0);
        // Alpha-dependent expectations: blended with the macro, layer 0 passes through without it.
`ifdef VIDEO_MIXER_ALPHA_EN
        a  = rgb(511, 511, 0);
        b2 = rgb(512, 1, 1);
`else
        a  = rgb(1023, 0, 0);
        b2 = rgb(1023, 0, 0);
`endif
        tbl[0]  = mk(-1, z, -1, z, 8'hFF, rgb(5, 6, 7), 8'd255, 1, 1, rgb(5, 6, 7), 4'd8);
        tbl[1]  = mk(3, rgb(100, 0, 0), 5, rgb(0, 200, 0), 8'hFF, rgb(9, 9, 9), 8'd0, 0, 1, rgb(100, 0, 0), 4'd3);
        tbl[2]  = mk(3, rgb(100, 0, 0), 5, rgb(0, 200, 0), 8'hF7, rgb(5, 6, 7), 8'd255, 1, 1, rgb(0, 200, 0), 4'd5);
        tbl[3]  = mk(3, rgb(100, 0, 0), 5, rgb(0, 200, 0), 8'hFF, rgb(9, 9, 9), 8'd0, 0, 1, rgb(0, 200, 0), 4'd5);
        tbl[4]  = mk(3, rgb(100, 0, 0), -1, z, 8'hFF, rgb(9, 9, 9), 8'd0, 0, 1, rgb(5, 6, 7), 4'd8);
        tbl[5]  = mk(5, rgb(0, 200, 0), -1, z, 8'hFF, rgb(9, 9, 9), 8'd0, 0, 0, z, 4'd5);
        tbl[6]  = mk(0, rgb(1023, 0, 0), 1, rgb(0, 1023, 0), 8'hFF, rgb(1, 2, 3), 8'd255, 1, 1, rgb(1023, 0, 0), 4'd0);
        tbl[7]  = mk(0, rgb(1023, 0, 0), 1, rgb(0, 1023, 0), 8'hFF, rgb(1, 2, 3), 8'd127, 1, 1, a, 4'd0);
        tbl[8]  = mk(0, rgb(1023, 0, 0), 1, rgb(0, 1023, 0), 8'h00, z, 8'd0, 0, 1, a, 4'd0);
        tbl[9]  = mk(1, rgb(0, 1023, 0), -1, z, 8'h00, z, 8'd0, 0, 1, rgb(0, 1023, 0), 4'd1);
        tbl[10] = mk(0, rgb(1023, 0, 0), -1, z, 8'h00, z, 8'd0, 0, 1, b2, 4'd0);
        tbl[11] = mk(7, rgb(4, 5, 6), -1, z, 8'h00, z, 8'd0, 0, 1, rgb(4, 5, 6), 4'd7);
        tbl[12] = mk(0, rgb(7, 7, 7), -1, z, 8'h00, rgb(10, 20, 30), 8'd200, 1, 1, rgb(10, 20, 30), 4'd8);
        tbl[13] = mk(2, rgb(1, 1, 1), -1, z, 8'hFF, z, 8'd255, 1, 1, rgb(1, 1, 1), 4'd2);

        // Clock/reset
        rst = 1'b1;
        drive_idle();
        cfg_layer_en = '0; cfg_bg_red = '0; cfg_bg_green = '0; cfg_bg_blue = '0; cfg_alpha = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_pix("reset", z, 4'd8);
        check("reset_timing", 32'({o_video_enable, o_hsync, o_vsync, o_frame_start, o_line_start}), 32'd0);
        check("reset_fcnt", 32'(frame_count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        check("fcnt_after_table", 32'(frame_count), 32'(fc_model));

        // Random timing: every output must equal its input three edges earlier.
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            logic [4:0] t;
            @(negedge clk);
            t = 5'($urandom_range(0, 31));
            drive_idle();
            {video_enable, hsync, vsync, frame_start, line_start} = t;
            if (t[1]) fc_model++;
            exp_q.push_back(t);
            @(posedge clk); #1;
            if (exp_q.size() == 3) begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check($sformatf("timing%0d", k),
                      32'({o_video_enable, o_hsync, o_vsync, o_frame_start, o_line_start}), 32'(e));
                if (!e[4]) check($sformatf("blank%0d", k), 32'({red, green, blue}), 32'd0);
            end
        end
        @(negedge clk); drive_idle();
        check("fcnt_after_random", 32'(frame_count), 32'(fc_model % 65536));

        // Mid-frame reset flush: nothing survives, new data needs three edges.
        lr[2] = 10'd9; lg[2] = 10'd9; lb[2] = 10'd9; hsync = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_pix("flush", z, 4'd8);
        check("flush_hsync", 32'(o_hsync), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k < 3) begin
                check_pix($sformatf("post_rst%0d", k), z, 4'd8);
                check($sformatf("post_rst%0d_hsync", k), 32'(o_hsync), 32'd0);
            end else begin
                check_pix("post_rst3", rgb(9, 9, 9), 4'd2);
                check("post_rst3_hsync", 32'(o_hsync), 32'd1);
            end
        end
        @(negedge clk); drive_idle();
        check("fcnt_zero_after_rst", 32'(frame_count), 32'd0);

        // Counter wrap: 65535 frame_starts, then one more.
        frame_start = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk); frame_start = 1'b0;
        check("fcnt_all_ones", 32'(frame_count), 32'hFFFF);
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        check("fcnt_wrap", 32'(frame_count), 32'd0);
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        check("fcnt_one", 32'(frame_count), 32'd1);

        // Reset beats a simultaneous frame_start carrying hostile config.
        @(negedge clk);
        rst = 1'b1; frame_start = 1'b1;
        cfg_layer_en = 8'h00; cfg_bg_red = 10'd50; cfg_bg_green = 10'd50; cfg_bg_blue = 10'd50;
        cfg_alpha = 8'd0;
        @(negedge clk); rst = 1'b0; frame_start = 1'b0;
        check("rst_fs_fcnt", 32'(frame_count), 32'd0);
        run_vec(mk(4, rgb(8, 8, 8), -1, z, 8'h00, rgb(50, 50, 50), 8'd0, 0, 1, rgb(8, 8, 8), 4'd4), "rst_mask");
        run_vec(mk(-1, z, -1, z, 8'h00, rgb(50, 50, 50), 8'd0, 0, 1, z, 4'd8), "rst_bg");
        run_vec(mk(0, rgb(100, 0, 0), 1, rgb(0, 100, 0), 8'h00, rgb(50, 50, 50), 8'd0, 0, 1,
                   rgb(100, 0, 0), 4'd0), "rst_alpha");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
